vbfs_gather: RTL and testbench
==============================

Name: vbfs_gather

Overview:
- Vertex-state owner for one BFS processing element; the producer side of the apply stage's input stream and the consumer of its state writeback.
- Accepts incoming BFS messages (sender→receiver), reads and updates the local vertex state, and presents node/state/round/barrier beats to apply under a ready handshake.
- Aggregates per-round barriers from all PEs into a single barrier toward apply.

Parameters:
- ADDR_W, 8, local vertex index width; state array has 2^ADDR_W entries indexed by receiver[ADDR_W-1:0].
- NUM_PE, 4, barriers required per round before one barrier is forwarded.

Ports:
- sys_clk in 1 clock.
- sys_rst_n in 1 asynchronous active-low reset.
- msg_sender in 32 sending node id.
- msg_receiver in 32 destination node id.
- msg_round in 2 BFS round of message.
- msg_barrier in 1 beat is a barrier, not a message.
- msg_valid in 1 message beat valid.
- msg_ack out 1 beat accepted this cycle.
- nodeid_out out 32 node presented to apply.
- state_out_parent out 32 parent of node.
- state_out_active out 1 node active.
- state_out_valid out 1 state changed; apply must act.
- valid_out out 1 beat valid.
- round_out out 2 round of beat.
- barrier_out out 1 beat is a barrier.
- apply_ready in 1 apply accepts beat.
- wb_nodeid in 32 writeback node.
- wb_parent in 32 writeback parent (ignored; parent is immutable once set).
- wb_active in 1 writeback active bit.
- wb_valid in 1 writeback strobe.
- wb_barrier in 1 writeback is barrier (no state write).
- wb_ack out 1 always 1 after reset.

Behaviour:
- Reset: all visited/active bits 0; pipeline empty; valid_out=0, all data outputs 0, msg_ack=0, wb_ack=0; barrier counter 0. Parent RAM is not reset.
- Pipeline: S1 registers the accepted beat and reads parent/visited/active; S2 decides and drives output registers. Latency is 2 cycles from msg_ack to valid_out with apply_ready held high.
- Advance condition: adv = !valid_out | apply_ready. msg_ack = msg_valid & adv & sys_rst_n. If adv is low, S1/S2 hold and outputs stay stable. Full throughput is 1 beat/cycle.
- Message, receiver not visited:
  - Write parent=sender, visited=1, active=1.
  - Emit nodeid=receiver, parent=sender, active=1, state_out_valid=1, round=msg_round, barrier_out=0.
- Message, receiver visited:
  - No write.
  - Emit the beat with state_out_valid=0, active=stored, parent=stored. Apply discards it.
- Hazard: the S2 write is forwarded into S1. Back-to-back messages to the same receiver make the second beat see visited=1 and the first sender as parent. First arrival wins.
- Barrier input:
  - Increments the counter and never touches state.
  - Count < NUM_PE after the increment: the beat is consumed and nothing is emitted.
  - Count reaches NUM_PE: emit barrier_out=1, valid_out=1, state_out_valid=0, round=msg_round, nodeid=0, and clear the counter.
  - Barrier order relative to messages is preserved.
- Writeback: when wb_valid & !wb_barrier, active[wb_nodeid[ADDR_W-1:0]] <= wb_active. If S2 sets active on the same index in the same cycle, the S2 set wins.
- Round mismatch among barriers is not checked. Any NUM_PE barriers forward one barrier carrying the round of the last one.
- Reset asserted mid-operation clears everything asynchronously. An in-flight beat is lost and valid_out drops immediately.

Decomposition:
- Shared vbfs package:
  - NODEID_W=32, ROUND_W=2.
  - Message struct {sender, receiver, round, barrier}.
  - Apply-input struct {nodeid, parent, active, state_valid, round, barrier}.
- One sub-module, vbfs_state_mem: 2^ADDR_W x 32 parent RAM plus visited/active flop arrays with async clear, 1 read port, S2 write port, separate active-clear port, and a priority rule.

Test Plan:
- Reset, then message sender=5 receiver=3 round=0 with apply_ready=1 → 2 cycles later valid_out=1, nodeid_out=3, parent=5, active=1, state_out_valid=1.
- Repeat message sender=7 receiver=3 → beat with state_out_valid=0, parent=5.
- Back-to-back messages to receiver=9 from senders 1 then 2 → first has state_out_valid=1, parent=1; second has state_out_valid=0, parent=1.
- NUM_PE=4: three barriers round=1 → no output; fourth → one beat with barrier_out=1, round_out=1, valid_out=1; counter restarts.
- apply_ready=0 for 5 cycles with msg_valid held → outputs stable, msg_ack=0 once S1 and S2 are full, no beat lost or duplicated after release.
- Writeback wb_nodeid=3, wb_active=0, then a message to 3 → emitted active=0, state_out_valid=0.
- Reset asserted mid-stream → valid_out=0 immediately; a subsequent message to 3 is treated as unvisited.

Source files
------------

// File: rtl/vbfs_pkg.sv
// Shared types for the BFS vertex pipeline: incoming message beats and the
// beats presented to the apply stage.
package vbfs_pkg;

   localparam int NODEID_W = 32;
   localparam int ROUND_W  = 2;

   typedef struct packed {
      logic [NODEID_W-1:0] sender;
      logic [NODEID_W-1:0] receiver;
      logic [ROUND_W-1:0]  round;
      logic                barrier;
   } msg_t;

   typedef struct packed {
      logic [NODEID_W-1:0] nodeid;
      logic [NODEID_W-1:0] parent;
      logic                active;
      logic                state_valid;
      logic [ROUND_W-1:0]  round;
      logic                barrier;
   } apply_t;

   function automatic apply_t make_beat(
      input logic [NODEID_W-1:0] nodeid,
      input logic [NODEID_W-1:0] parent,
      input logic                active,
      input logic                state_valid,
      input logic [ROUND_W-1:0]  round,
      input logic                barrier
   );
      apply_t b;
      b.nodeid      = nodeid;
      b.parent      = parent;
      b.active      = active;
      b.state_valid = state_valid;
      b.round       = round;
      b.barrier     = barrier;
      return b;
   endfunction

endpackage

// File: rtl/vbfs_state_mem.sv
// Per-vertex state: parent RAM (never cleared) plus visited/active flag arrays.
// A first-visit set on the same index as an active writeback takes priority.
module vbfs_state_mem
   import vbfs_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [NODEID_W-1:0] rd_parent,
   output logic                rd_visited,
   output logic                rd_active,
   input  logic                set_en,
   input  logic [ADDR_W-1:0]   set_addr,
   input  logic [NODEID_W-1:0] set_parent,
   input  logic                clr_en,
   input  logic [ADDR_W-1:0]   clr_addr,
   input  logic                clr_val
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [NODEID_W-1:0] parent_q [DEPTH];
   logic [DEPTH-1:0]    visited_q;
   logic [DEPTH-1:0]    visited_d;
   logic [DEPTH-1:0]    active_q;
   logic [DEPTH-1:0]    active_d;

   always_comb begin
      visited_d = visited_q;
      active_d  = active_q;
      if (clr_en) begin
         active_d[clr_addr] = clr_val;
      end else begin
         active_d = active_q;
      end
      // applied last so the first-visit set overrides a same-index writeback
      if (set_en) begin
         visited_d[set_addr] = 1'b1;
         active_d[set_addr]  = 1'b1;
      end else begin
         visited_d = visited_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         visited_q <= '0;
         active_q  <= '0;
      end else begin
         visited_q <= visited_d;
         active_q  <= active_d;
      end
   end

   always_ff @(posedge clk) begin
      if (set_en) begin
         parent_q[set_addr] <= set_parent;
      end
   end

   assign rd_parent  = parent_q[rd_addr];
   assign rd_visited = visited_q[rd_addr];
   assign rd_active  = active_q[rd_addr];

endmodule

// File: rtl/vbfs_gather.sv
// BFS gather stage: two-stage pipeline that resolves first-arrival parents,
// feeds the apply stage under ready/valid, and folds NUM_PE barriers into one.
module vbfs_gather
   import vbfs_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int NUM_PE = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [NODEID_W-1:0] msg_sender,
   input  logic [NODEID_W-1:0] msg_receiver,
   input  logic [ROUND_W-1:0]  msg_round,
   input  logic                msg_barrier,
   input  logic                msg_valid,
   output logic                msg_ack,
   output logic [NODEID_W-1:0] nodeid_out,
   output logic [NODEID_W-1:0] state_out_parent,
   output logic                state_out_active,
   output logic                state_out_valid,
   output logic                valid_out,
   output logic [ROUND_W-1:0]  round_out,
   output logic                barrier_out,
   input  logic                apply_ready,
   input  logic [NODEID_W-1:0] wb_nodeid,
   input  logic [NODEID_W-1:0] wb_parent,
   input  logic                wb_active,
   input  logic                wb_valid,
   input  logic                wb_barrier,
   output logic                wb_ack
);

   localparam int              CNT_W    = $clog2(NUM_PE + 1);
   localparam logic [CNT_W-1:0] NUM_PE_C = CNT_W'(NUM_PE);

   msg_t             msg_in_s;
   msg_t             s1_msg_q, s1_msg_d;
   logic             s1_valid_q, s1_valid_d;
   apply_t           out_q, out_d;
   logic             valid_out_q, valid_out_d;
   logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d, bar_next_s;
   logic             wb_ack_q, wb_ack_d;
   logic             adv_s;

   logic [NODEID_W-1:0] rd_parent_s;
   logic                rd_visited_s;
   logic                rd_active_s;
   logic                set_en_s;
   logic                clr_en_s;
   logic                unused_wb_s;

   assign msg_in_s = '{sender:   msg_sender,
                       receiver: msg_receiver,
                       round:    msg_round,
                       barrier:  msg_barrier};

   assign adv_s       = !valid_out_q | apply_ready;
   assign msg_ack     = msg_valid & adv_s & sys_rst_n;
   assign clr_en_s    = wb_valid & !wb_barrier;
   assign bar_next_s  = bar_cnt_q + CNT_W'(1);
   assign unused_wb_s = ^{wb_parent, wb_nodeid[NODEID_W-1:ADDR_W]};

   vbfs_state_mem #(.ADDR_W(ADDR_W)) u_state_mem (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .rd_addr    (s1_msg_q.receiver[ADDR_W-1:0]),
      .rd_parent  (rd_parent_s),
      .rd_visited (rd_visited_s),
      .rd_active  (rd_active_s),
      .set_en     (set_en_s),
      .set_addr   (s1_msg_q.receiver[ADDR_W-1:0]),
      .set_parent (s1_msg_q.sender),
      .clr_en     (clr_en_s),
      .clr_addr   (wb_nodeid[ADDR_W-1:0]),
      .clr_val    (wb_active)
   );

   // The state write lands on the same edge S2 loads, so the next beat in S1
   // already reads the updated visited/parent: first arrival wins.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_msg_d    = s1_msg_q;
      out_d       = out_q;
      valid_out_d = valid_out_q;
      bar_cnt_d   = bar_cnt_q;
      set_en_s    = 1'b0;
      wb_ack_d    = 1'b1;
      if (adv_s) begin
         s1_valid_d  = msg_ack;
         s1_msg_d    = msg_in_s;
         out_d       = '0;
         valid_out_d = 1'b0;
         if (s1_valid_q) begin
            if (s1_msg_q.barrier) begin
               if (bar_next_s == NUM_PE_C) begin
                  valid_out_d = 1'b1;
                  out_d       = make_beat('0, '0, 1'b0, 1'b0, s1_msg_q.round, 1'b1);
                  bar_cnt_d   = '0;
               end else begin
                  bar_cnt_d   = bar_next_s;
               end
            end else if (!rd_visited_s) begin
               set_en_s    = 1'b1;
               valid_out_d = 1'b1;
               out_d       = make_beat(s1_msg_q.receiver, s1_msg_q.sender, 1'b1,
                                       1'b1, s1_msg_q.round, 1'b0);
            end else begin
               valid_out_d = 1'b1;
               out_d       = make_beat(s1_msg_q.receiver, rd_parent_s, rd_active_s,
                                       1'b0, s1_msg_q.round, 1'b0);
            end
         end else begin
            bar_cnt_d = bar_cnt_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_msg_q    <= '0;
         out_q       <= '0;
         valid_out_q <= 1'b0;
         bar_cnt_q   <= '0;
         wb_ack_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_msg_q    <= s1_msg_d;
         out_q       <= out_d;
         valid_out_q <= valid_out_d;
         bar_cnt_q   <= bar_cnt_d;
         wb_ack_q    <= wb_ack_d;
      end
   end

   assign nodeid_out       = out_q.nodeid;
   assign state_out_parent = out_q.parent;
   assign state_out_active = out_q.active;
   assign state_out_valid  = out_q.state_valid;
   assign round_out        = out_q.round;
   assign barrier_out      = out_q.barrier;
   assign valid_out        = valid_out_q;
   assign wb_ack           = wb_ack_q;

endmodule

// File: tb/tb_vbfs_gather.sv
// Self-checking bench for vbfs_gather: directed scenarios plus random traffic
// scored against an array/queue model of BFS first-arrival semantics.
module tb_vbfs_gather;

   localparam int NUM_PE = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic [31:0] msg_sender, msg_receiver;
   logic [1:0]  msg_round;
   logic        msg_barrier, msg_valid, msg_ack;
   logic [31:0] nodeid_out, state_out_parent;
   logic        state_out_active, state_out_valid, valid_out;
   logic [1:0]  round_out;
   logic        barrier_out, apply_ready;
   logic [31:0] wb_nodeid, wb_parent;
   logic        wb_active, wb_valid, wb_barrier, wb_ack;

   always #5 sys_clk = ~sys_clk;

   vbfs_gather #(.ADDR_W(8), .NUM_PE(NUM_PE)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .msg_sender(msg_sender), .msg_receiver(msg_receiver), .msg_round(msg_round),
      .msg_barrier(msg_barrier), .msg_valid(msg_valid), .msg_ack(msg_ack),
      .nodeid_out(nodeid_out), .state_out_parent(state_out_parent),
      .state_out_active(state_out_active), .state_out_valid(state_out_valid),
      .valid_out(valid_out), .round_out(round_out), .barrier_out(barrier_out),
      .apply_ready(apply_ready),
      .wb_nodeid(wb_nodeid), .wb_parent(wb_parent), .wb_active(wb_active),
      .wb_valid(wb_valid), .wb_barrier(wb_barrier), .wb_ack(wb_ack)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] nodeid;
      logic [31:0] parent;
      logic        active;
      logic        sv;
      logic [1:0]  round;
      logic        barrier;
   } beat_t;

   beat_t       exp_q[$];
   bit          m_visited[256];
   bit          m_active[256];
   logic [31:0] m_parent[256];
   int          m_bar;

   function automatic void model_reset();
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         m_visited[i] = 1'b0;
         m_active[i]  = 1'b0;
      end
      m_bar = 0;
   endfunction

   function automatic void model_accept(input logic [31:0] s, input logic [31:0] r,
                                        input logic [1:0] rd, input logic b);
      beat_t nb;
      int idx;
      idx = int'(r[7:0]);
      if (b) begin
         m_bar = m_bar + 1;
         if (m_bar == NUM_PE) begin
            nb = '{nodeid: 32'd0, parent: 32'd0, active: 1'b0, sv: 1'b0, round: rd, barrier: 1'b1};
            exp_q.push_back(nb);
            m_bar = 0;
         end
      end else if (!m_visited[idx]) begin
         m_visited[idx] = 1'b1;
         m_active[idx]  = 1'b1;
         m_parent[idx]  = s;
         nb = '{nodeid: r, parent: s, active: 1'b1, sv: 1'b1, round: rd, barrier: 1'b0};
         exp_q.push_back(nb);
      end else begin
         nb = '{nodeid: r, parent: m_parent[idx], active: m_active[idx], sv: 1'b0,
                round: rd, barrier: 1'b0};
         exp_q.push_back(nb);
      end
   endfunction

   // ---------------- monitor / scoreboard ----------------
   beat_t e, prev;
   bit    prev_stall = 1'b0;
   bit    was_up = 1'b0;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         check_eq("rst_valid_out", valid_out, 1'b0);
         check_eq("rst_msg_ack", msg_ack, 1'b0);
         check_eq("rst_wb_ack", wb_ack, 1'b0);
         model_reset();
         prev_stall = 1'b0;
         was_up = 1'b0;
      end else begin
         if (was_up) check_eq("wb_ack_high", wb_ack, 1'b1);
         check_eq("ack_rule", msg_ack, msg_valid & (!valid_out | apply_ready));
         if (prev_stall) begin
            check_eq("stall_valid", valid_out, 1'b1);
            check_eq("stall_node", nodeid_out, prev.nodeid);
            check_eq("stall_parent", state_out_parent, prev.parent);
            check_eq("stall_flags", {state_out_active, state_out_valid, round_out, barrier_out},
                     {prev.active, prev.sv, prev.round, prev.barrier});
         end
         if (valid_out && apply_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_beat", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check_eq("sb_barrier", barrier_out, e.barrier);
               check_eq("sb_round", round_out, e.round);
               check_eq("sb_state_valid", state_out_valid, e.sv);
               check_eq("sb_nodeid", nodeid_out, e.nodeid);
               if (!e.barrier) begin
                  check_eq("sb_parent", state_out_parent, e.parent);
                  check_eq("sb_active", state_out_active, e.active);
               end
            end
         end
         if (wb_valid && !wb_barrier) m_active[int'(wb_nodeid[7:0])] = wb_active;
         if (msg_ack) model_accept(msg_sender, msg_receiver, msg_round, msg_barrier);
         prev_stall = valid_out & !apply_ready;
         prev = '{nodeid: nodeid_out, parent: state_out_parent, active: state_out_active,
                  sv: state_out_valid, round: round_out, barrier: barrier_out};
         was_up = 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] s, input logic [31:0] r,
                        input logic [1:0] rd, input logic b);
      msg_sender = s; msg_receiver = r; msg_round = rd; msg_barrier = b; msg_valid = 1'b1;
   endtask

   task automatic idle();
      msg_valid = 1'b0;
      msg_barrier = 1'b0;
   endtask

   task automatic send1(input logic [31:0] s, input logic [31:0] r,
                        input logic [1:0] rd, input logic b);
      drive(s, r, rd, b);
      #1 check_eq("send_ack", msg_ack, 1'b1);
      tick();
      idle();
   endtask

   task automatic check_out(input string tag, input logic [31:0] node, input logic [31:0] par,
                            input logic act, input logic sv, input logic [1:0] rd);
      check_eq({tag, "_valid"}, valid_out, 1'b1);
      check_eq({tag, "_node"}, nodeid_out, node);
      check_eq({tag, "_parent"}, state_out_parent, par);
      check_eq({tag, "_active"}, state_out_active, act);
      check_eq({tag, "_sv"}, state_out_valid, sv);
      check_eq({tag, "_round"}, round_out, rd);
      check_eq({tag, "_barrier"}, barrier_out, 1'b0);
   endtask

   task automatic drain();
      idle();
      apply_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      check_eq("drain_empty", exp_q.size() == 0, 1'b1);
      tick();
      tick();
   endtask

   task automatic rand_phase(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         msg_valid    = ($urandom_range(0, 9) < 7);
         msg_barrier  = ($urandom_range(0, 4) == 0);
         msg_sender   = $urandom;
         msg_receiver = $urandom & 32'hF000_030F;
         msg_round    = 2'($urandom_range(0, 3));
         apply_ready  = ($urandom_range(0, 3) != 0);
      end
      idle();
   endtask

   // ---------------- directed + random sequence ----------------
   int acks;

   initial begin
      msg_sender = 32'd0; msg_receiver = 32'd0; msg_round = 2'd0;
      msg_barrier = 1'b0; msg_valid = 1'b0; apply_ready = 1'b1;
      wb_nodeid = 32'd0; wb_parent = 32'd0; wb_active = 1'b0;
      wb_valid = 1'b0; wb_barrier = 1'b0;
      #2 sys_rst_n = 1'b0;
      tick(); tick();
      msg_valid = 1'b1;
      #1;
      check_eq("reset_valid_out", valid_out, 1'b0);
      check_eq("reset_nodeid", nodeid_out, 32'd0);
      check_eq("reset_msg_ack", msg_ack, 1'b0);
      check_eq("reset_wb_ack", wb_ack, 1'b0);
      msg_valid = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      tick();
      check_eq("wb_ack_after_reset", wb_ack, 1'b1);

      // first visit, 2-cycle latency
      send1(32'd5, 32'd3, 2'd0, 1'b0);
      check_eq("latency_not_early", valid_out, 1'b0);
      tick();
      check_out("first_visit", 32'd3, 32'd5, 1'b1, 1'b1, 2'd0);

      // revisit keeps original parent
      send1(32'd7, 32'd3, 2'd0, 1'b0);
      tick();
      check_out("revisit", 32'd3, 32'd5, 1'b1, 1'b0, 2'd0);

      // back-to-back hazard on receiver 9
      drive(32'd1, 32'd9, 2'd1, 1'b0);
      tick();
      drive(32'd2, 32'd9, 2'd1, 1'b0);
      tick();
      idle();
      check_out("b2b_first", 32'd9, 32'd1, 1'b1, 1'b1, 2'd1);
      tick();
      check_out("b2b_second", 32'd9, 32'd1, 1'b1, 1'b0, 2'd1);

      // barrier aggregation
      for (int i = 0; i < 3; i++) begin
         drive(32'd0, 32'd0, 2'd1, 1'b1);
         tick();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("barrier_quiet", valid_out, 1'b0);
      end
      send1(32'd0, 32'd0, 2'd1, 1'b1);
      tick();
      check_eq("barrier_valid", valid_out, 1'b1);
      check_eq("barrier_flag", barrier_out, 1'b1);
      check_eq("barrier_round", round_out, 2'd1);
      check_eq("barrier_sv", state_out_valid, 1'b0);
      check_eq("barrier_node", nodeid_out, 32'd0);
      tick();
      check_eq("barrier_once", valid_out, 1'b0);

      // backpressure with msg_valid held
      apply_ready = 1'b0;
      drive(32'd100, 32'd20, 2'd3, 1'b0);
      acks = 0;
      repeat (5) begin
         #1;
         if (msg_ack) acks++;
         tick();
      end
      check_eq("stall_ack_count", acks, 2);
      check_eq("stall_ack_low", msg_ack, 1'b0);
      check_out("stall_head", 32'd20, 32'd100, 1'b1, 1'b1, 2'd3);
      drain();

      // writeback clears active; barrier writeback writes nothing
      wb_nodeid = 32'hABCD_0003; wb_active = 1'b0; wb_barrier = 1'b0; wb_valid = 1'b1;
      tick();
      wb_nodeid = 32'd9; wb_active = 1'b0; wb_barrier = 1'b1;
      tick();
      wb_valid = 1'b0; wb_barrier = 1'b0;
      send1(32'd8, 32'd3, 2'd2, 1'b0);
      tick();
      check_out("wb_cleared", 32'd3, 32'd5, 1'b0, 1'b0, 2'd2);
      send1(32'd4, 32'd9, 2'd1, 1'b0);
      tick();
      check_out("wb_barrier_nowrite", 32'd9, 32'd1, 1'b1, 1'b0, 2'd1);

      // random traffic with writebacks in quiet windows
      rand_phase(400);
      drain();
      for (int i = 0; i < 24; i++) begin
         wb_valid   = ($urandom_range(0, 1) == 1);
         wb_barrier = ($urandom_range(0, 3) == 0);
         wb_nodeid  = $urandom & 32'hFFFF_FF0F;
         wb_parent  = $urandom;
         wb_active  = ($urandom_range(0, 1) == 1);
         tick();
      end
      wb_valid = 1'b0;
      rand_phase(400);
      drain();

      // reset while a beat is presented
      drive(32'd60, 32'd50, 2'd0, 1'b0);
      tick();
      idle();
      tick();
      check_eq("pre_reset_valid", valid_out, 1'b1);
      sys_rst_n = 1'b0;
      #1 check_eq("mid_reset_valid_drop", valid_out, 1'b0);
      tick();
      tick();
      sys_rst_n = 1'b1;
      tick();
      send1(32'd11, 32'd3, 2'd0, 1'b0);
      tick();
      check_out("post_reset_unvisited", 32'd3, 32'd11, 1'b1, 1'b1, 2'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
